// File: rtl/secuenciador_alu.sv
// secuenciador_alu: sequences one ALU operation per command, holds operands through a settle
// latency, captures result/flags and hands them downstream over valid/ready.
module secuenciador_alu #(
  parameter int ancho        = 3,
  parameter int LATENCIA_ALU = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valido,
  output logic             cmd_listo,
  input  logic [ancho:0]   cmd_operandoA,
  input  logic [ancho:0]   cmd_operandoB,
  input  logic [3:0]       cmd_seleccion,
  output logic [ancho:0]   alu_operandoA,
  output logic [ancho:0]   alu_operandoB,
  output logic [3:0]       alu_seleccion,
  input  logic [ancho:0]   alu_resultado,
  input  logic [3:0]       alu_banderas,
  output logic             res_valido,
  input  logic             res_listo,
  output logic [ancho:0]   res_resultado,
  output logic [3:0]       res_banderas,
  output logic             res_error,
  output logic [7:0]       contador_ops
);
  typedef enum logic [1:0] {IDLE, ESPERA, ENTREGA} estado_t;
  estado_t r_estado, w_siguiente;
  logic [3:0] r_cuenta;
  logic       r_error;
  logic       w_acepta, w_captura, w_entrega, w_soportado;
  assign cmd_listo   = (r_estado == IDLE) && !rst;
  assign w_acepta    = cmd_valido && cmd_listo;
  assign w_captura   = (r_estado == ESPERA) && (r_cuenta == 4'd1);
  assign w_entrega   = res_valido && res_listo;
  assign w_soportado = cmd_seleccion inside {4'b0000, 4'b0001, 4'b0101};
  always_ff @(posedge clk or posedge rst)
    if (rst) r_estado <= IDLE;
    else r_estado <= w_siguiente;
  always_comb begin
    w_siguiente = r_estado;
    if (w_acepta) w_siguiente = ESPERA;
    if (w_captura) w_siguiente = ENTREGA;
    if (w_entrega) w_siguiente = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      alu_operandoA <= '0;
      alu_operandoB <= '0;
      alu_seleccion <= '0;
      res_valido    <= 1'b0;
      res_resultado <= '0;
      res_banderas  <= '0;
      res_error     <= 1'b0;
      contador_ops  <= '0;
      r_cuenta      <= '0;
      r_error       <= 1'b0;
    end else begin
      if (w_acepta) begin
        alu_operandoA <= cmd_operandoA;
        alu_operandoB <= cmd_operandoB;
        alu_seleccion <= w_soportado ? cmd_seleccion : 4'b0000;
        r_error       <= !w_soportado;
        r_cuenta      <= 4'(LATENCIA_ALU);
      end
      if (r_estado == ESPERA) r_cuenta <= r_cuenta - 4'd1;
      if (w_captura) begin
        res_resultado <= alu_resultado;
        res_banderas  <= alu_banderas;
        res_error     <= r_error;
        res_valido    <= 1'b1;
      end
      if (w_entrega) begin
        res_valido   <= 1'b0;
        contador_ops <= contador_ops + 8'd1;
      end
    end
endmodule

// File: tb/tb_secuenciador_alu.sv
// tb_secuenciador_alu: directed and randomized checks of the ALU sequencer against a behavioural model.
module tb_secuenciador_alu;
  logic clk = 1'b0, rst = 1'b1, rst4 = 1'b1;
  always #5 clk = ~clk;
  logic       cmd_valido = 0, cmd_listo, res_valido, res_listo = 0, res_error;
  logic [3:0] cmd_operandoA = 0, cmd_operandoB = 0, cmd_seleccion = 0;
  logic [3:0] alu_operandoA, alu_operandoB, alu_seleccion, alu_resultado, alu_banderas;
  logic [3:0] res_resultado, res_banderas;
  logic [7:0] contador_ops;
  logic       d4_cmd_valido = 0, d4_cmd_listo, d4_res_valido, d4_res_error;
  logic [3:0] d4_cmd_operandoA = 0, d4_cmd_operandoB = 0, d4_cmd_seleccion = 0;
  logic [3:0] d4_alu_operandoA, d4_alu_operandoB, d4_alu_seleccion, d4_alu_resultado, d4_alu_banderas;
  logic [3:0] d4_res_resultado, d4_res_banderas;
  logic [7:0] d4_contador_ops;
  int n_chk = 0, n_fail = 0;

  function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel);
    int sa, sb, r;
    logic [3:0] y;
    logic c, v;
    sa = (a >= 8) ? int'(a) - 16 : int'(a);
    sb = (b >= 8) ? int'(b) - 16 : int'(b);
    c = 0; v = 0; y = 0; r = 0;
    if (sel == 4'd0) begin
      r = int'(a) + int'(b); y = r[3:0]; c = r > 15; v = (sa + sb > 7) || (sa + sb < -8);
    end else if (sel == 4'd1) begin
      r = int'(a) - int'(b); y = r[3:0]; c = a < b; v = (sa - sb > 7) || (sa - sb < -8);
    end else if (sel == 4'd5) y = a & b;
    return {y[3], y == 4'd0, c, v, y};
  endfunction

  function automatic logic [8:0] esperado(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel);
    logic ok;
    ok = (sel == 4'd0) || (sel == 4'd1) || (sel == 4'd5);
    return {!ok, alu_f(a, b, ok ? sel : 4'd0)};
  endfunction

  assign {alu_banderas, alu_resultado} = alu_f(alu_operandoA, alu_operandoB, alu_seleccion);
  assign {d4_alu_banderas, d4_alu_resultado} = alu_f(d4_alu_operandoA, d4_alu_operandoB, d4_alu_seleccion);

  secuenciador_alu #(.ancho(3), .LATENCIA_ALU(1)) dut (
    .clk(clk), .rst(rst), .cmd_valido(cmd_valido), .cmd_listo(cmd_listo),
    .cmd_operandoA(cmd_operandoA), .cmd_operandoB(cmd_operandoB), .cmd_seleccion(cmd_seleccion),
    .alu_operandoA(alu_operandoA), .alu_operandoB(alu_operandoB), .alu_seleccion(alu_seleccion),
    .alu_resultado(alu_resultado), .alu_banderas(alu_banderas), .res_valido(res_valido),
    .res_listo(res_listo), .res_resultado(res_resultado), .res_banderas(res_banderas),
    .res_error(res_error), .contador_ops(contador_ops));

  secuenciador_alu #(.ancho(3), .LATENCIA_ALU(4)) dut4 (
    .clk(clk), .rst(rst4), .cmd_valido(d4_cmd_valido), .cmd_listo(d4_cmd_listo),
    .cmd_operandoA(d4_cmd_operandoA), .cmd_operandoB(d4_cmd_operandoB), .cmd_seleccion(d4_cmd_seleccion),
    .alu_operandoA(d4_alu_operandoA), .alu_operandoB(d4_alu_operandoB), .alu_seleccion(d4_alu_seleccion),
    .alu_resultado(d4_alu_resultado), .alu_banderas(d4_alu_banderas), .res_valido(d4_res_valido),
    .res_listo(1'b1), .res_resultado(d4_res_resultado), .res_banderas(d4_res_banderas),
    .res_error(d4_res_error), .contador_ops(d4_contador_ops));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic directo(input string tag, input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel, input logic [7:0] cnt);
    logic [8:0] e;
    e = esperado(a, b, sel);
    cmd_valido = 1; cmd_operandoA = a; cmd_operandoB = b; cmd_seleccion = sel; res_listo = 1;
    chk({tag, "_listo0"}, cmd_listo, 1);
    @(negedge clk);
    cmd_valido = 0; cmd_operandoA = ~a;
    chk({tag, "_aluA"}, alu_operandoA, a);
    chk({tag, "_aluB"}, alu_operandoB, b);
    chk({tag, "_aluSel"}, alu_seleccion, e[8] ? 4'd0 : sel);
    chk({tag, "_listo1"}, cmd_listo, 0);
    chk({tag, "_valido1"}, res_valido, 0);
    @(negedge clk);
    chk({tag, "_valido2"}, res_valido, 1);
    chk({tag, "_res"}, res_resultado, e[3:0]);
    chk({tag, "_flags"}, res_banderas, e[7:4]);
    chk({tag, "_err"}, res_error, e[8]);
    chk({tag, "_listo2"}, cmd_listo, 0);
    @(negedge clk);
    chk({tag, "_valido3"}, res_valido, 0);
    chk({tag, "_cnt"}, contador_ops, cnt);
    chk({tag, "_listo3"}, cmd_listo, 1);
  endtask

  initial begin
    logic [8:0] q[$];
    logic [8:0] e;
    logic [3:0] codes [4];
    int n_acc, n_del;
    repeat (2) @(negedge clk);
    chk("rst_listo", cmd_listo, 0);
    chk("rst_valido", res_valido, 0);
    chk("rst_aluA", alu_operandoA, 0);
    chk("rst_cnt", contador_ops, 0);
    rst = 0; rst4 = 0;
    @(negedge clk);
    directo("suma", 4'd5, 4'd3, 4'b0000, 8'd1);
    chk("suma_flags_spec", res_banderas, 4'b1001);
    chk("suma_res_spec", res_resultado, 4'd8);
    directo("resta", 4'd2, 4'd5, 4'b0001, 8'd2);
    chk("resta_res_spec", res_resultado, 4'hD);
    chk("resta_N", res_banderas[3], 1);
    // backpressure: result held, a stray command must not be taken
    cmd_valido = 1; cmd_operandoA = 4'hC; cmd_operandoB = 4'hA; cmd_seleccion = 4'b0101; res_listo = 0;
    @(negedge clk);
    cmd_valido = 0;
    @(negedge clk);
    cmd_valido = 1; cmd_operandoA = 4'h3; cmd_operandoB = 4'h3; cmd_seleccion = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valido", res_valido, 1);
      chk("bp_res", res_resultado, 4'h8);
      chk("bp_listo", cmd_listo, 0);
      chk("bp_aluA", alu_operandoA, 4'hC);
      @(negedge clk);
    end
    chk("bp_cnt_hold", contador_ops, 2);
    res_listo = 1; cmd_valido = 0;
    @(negedge clk);
    chk("bp_valido_done", res_valido, 0);
    chk("bp_cnt", contador_ops, 3);
    chk("bp_res_keep", res_resultado, 4'h8);
    directo("noSop", 4'd1, 4'd1, 4'b0011, 8'd4);
    chk("noSop_res_spec", res_resultado, 4'd2);
    // asynchronous reset two cycles after accept in the LATENCIA_ALU=4 instance
    d4_cmd_valido = 1; d4_cmd_operandoA = 4'd9; d4_cmd_operandoB = 4'd6; d4_cmd_seleccion = 4'b0001;
    @(negedge clk);
    d4_cmd_valido = 0;
    chk("r4_aluA_pre", d4_alu_operandoA, 4'd9);
    @(negedge clk);
    #2 rst4 = 1;
    #1;
    chk("r4_aluA", d4_alu_operandoA, 0);
    chk("r4_aluB", d4_alu_operandoB, 0);
    chk("r4_aluSel", d4_alu_seleccion, 0);
    chk("r4_listo", d4_cmd_listo, 0);
    chk("r4_valido", d4_res_valido, 0);
    @(negedge clk);
    rst4 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("r4_no_valido", d4_res_valido, 0);
    end
    chk("r4_cnt", d4_contador_ops, 0);
    chk("r4_listo_post", d4_cmd_listo, 1);
    // 256 back-to-back random commands
    rst = 1;
    @(negedge clk);
    rst = 0; res_listo = 1; n_acc = 0; n_del = 0;
    codes[0] = 4'd0; codes[1] = 4'd1; codes[2] = 4'd5;
    for (int c = 0; c < 256 * 3 + 6; c++) begin
      @(negedge clk);
      chk("rnd_listo", cmd_listo, (c < 768) ? (c % 3 == 0) : 1);
      chk("rnd_valido", res_valido, (c < 768) && (c % 3 == 2));
      if (res_valido) begin
        chk("rnd_queue", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("rnd_res", res_resultado, e[3:0]);
          chk("rnd_flags", res_banderas, e[7:4]);
          chk("rnd_err", res_error, e[8]);
          n_del++;
        end
      end
      codes[3] = 4'($urandom_range(0, 15));
      cmd_operandoA = 4'($urandom);
      cmd_operandoB = 4'($urandom);
      cmd_seleccion = codes[$urandom_range(0, 3)];
      cmd_valido = n_acc < 256;
      if (cmd_valido && cmd_listo) begin
        q.push_back(esperado(cmd_operandoA, cmd_operandoB, cmd_seleccion));
        n_acc++;
      end
    end
    chk("rnd_deliveries", n_del, 256);
    chk("rnd_cnt_wrap", contador_ops, 0);
    chk("rnd_queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
